// File: rtl/hazard_pkg.sv
// Shared opcode/funct constants, counter width and decode payload for the hazard unit.
// Optional feature macro: HAZARD_JR_EN (jr treated as branch + jump).
package hazard_pkg;

  localparam int unsigned CNT_W = 16;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] FN_JR     = 6'b001000;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       is_branch;
    logic       is_jump;
  } dec_t;

  // True when rd is a nonzero register that the decoded instruction reads.
  function automatic logic src_hit(input dec_t d, input logic [4:0] rd);
    return (rd != 5'd0) && ((d.uses_rs && (d.rs == rd)) || (d.uses_rt && (d.rt == rd)));
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// ID-stage instruction classifier: register usage, branch and jump flags.
// Optional feature macro: HAZARD_JR_EN.
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec_c
);

  logic [5:0] opcode;

  assign opcode = instr[31:26];

`ifdef HAZARD_JR_EN
  logic [5:0] funct;
  logic       unused_bits;
  assign funct       = instr[5:0];
  assign unused_bits = ^instr[15:6];
`else
  logic unused_bits;
  assign unused_bits = ^instr[15:0];
`endif

  always_comb begin
    dec_c           = '0;
    dec_c.rs        = instr[25:21];
    dec_c.rt        = instr[20:16];
    dec_c.uses_rs   = !((opcode == OP_J) || (opcode == OP_JAL));
    dec_c.uses_rt   = opcode inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_SH, OP_SB};
    dec_c.is_branch = opcode inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM};
    dec_c.is_jump   = opcode inside {OP_J, OP_JAL};
`ifdef HAZARD_JR_EN
    // jr resolves in ID, so it needs its source ready like a branch and redirects like a jump.
    if ((opcode == OP_RTYPE) && (funct == FN_JR)) begin
      dec_c.is_branch = 1'b1;
      dec_c.is_jump   = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard detection: load-use / branch stalls, branch/jump flush, saturating event counters.
// Optional feature macro: HAZARD_JR_EN.
module hazard_unit
  import hazard_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic [31:0]      ID_Instruction,
  input  logic             comp_in,
  input  logic [4:0]       EX_Rd,
  input  logic [1:0]       EX_regWrite,
  input  logic [1:0]       EX_memRead,
  input  logic [4:0]       MEM_Rd,
  input  logic             MEM_regWrite,
  input  logic             MEM_memRead,
  output logic             stall_mux,
  output logic             flush,
  output logic             PCoff,
  output logic             IFID_writeOff,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  dec_t             dec;
  logic             load_use;
  logic             branch_haz;
  logic             stall_c;
  logic             flush_c;
  logic [CNT_W-1:0] stall_count_d, stall_count_q;
  logic [CNT_W-1:0] flush_count_d, flush_count_q;

  // ALU results sitting in MEM are forwarded, so MEM write-enable never causes a hazard.
  logic unused_mem_rw;
  assign unused_mem_rw = MEM_regWrite;

  hazard_decode u_decode (
    .instr (ID_Instruction),
    .dec_c (dec)
  );

  always_comb begin
    load_use      = 1'b0;
    branch_haz    = 1'b0;
    stall_c       = 1'b0;
    flush_c       = 1'b0;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;

    load_use   = (|EX_memRead) && src_hit(dec, EX_Rd);
    branch_haz = dec.is_branch &&
                 (((|EX_regWrite) && src_hit(dec, EX_Rd)) ||
                  (MEM_memRead && src_hit(dec, MEM_Rd)));

    stall_c = !Rst && (load_use || branch_haz);
    flush_c = !Rst && !stall_c && ((dec.is_branch && comp_in) || dec.is_jump);

    if (stall_c && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    if (flush_c && (flush_count_q != {CNT_W{1'b1}})) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_mux     = stall_c;
  assign PCoff         = stall_c;
  assign IFID_writeOff = stall_c;
  assign flush         = flush_c;
  assign stall_count   = stall_count_q;
  assign flush_count   = flush_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a rule-level reference model checked every cycle.
// Honours HAZARD_JR_EN the same way as the design.
module tb_hazard_unit;

`ifdef HAZARD_JR_EN
  localparam bit JR_ON = 1'b1;
`else
  localparam bit JR_ON = 1'b0;
`endif

  logic        Clk;
  logic        Rst;
  logic [31:0] ID_Instruction;
  logic        comp_in;
  logic [4:0]  EX_Rd;
  logic [1:0]  EX_regWrite;
  logic [1:0]  EX_memRead;
  logic [4:0]  MEM_Rd;
  logic        MEM_regWrite;
  logic        MEM_memRead;
  logic        stall_mux;
  logic        flush;
  logic        PCoff;
  logic        IFID_writeOff;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  hazard_unit dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .ID_Instruction(ID_Instruction),
    .comp_in       (comp_in),
    .EX_Rd         (EX_Rd),
    .EX_regWrite   (EX_regWrite),
    .EX_memRead    (EX_memRead),
    .MEM_Rd        (MEM_Rd),
    .MEM_regWrite  (MEM_regWrite),
    .MEM_memRead   (MEM_memRead),
    .stall_mux     (stall_mux),
    .flush         (flush),
    .PCoff         (PCoff),
    .IFID_writeOff (IFID_writeOff),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;
  int m_scnt  = 0;
  int m_fcnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model straight from the hazard rules, using register lists rather than flags.
  task automatic model(output bit st, output bit fl);
    int op, rs, rt, fn;
    bit is_jr, br, jmp, lu, bh;
    int srcs[$];
    op = int'(ID_Instruction[31:26]);
    rs = int'(ID_Instruction[25:21]);
    rt = int'(ID_Instruction[20:16]);
    fn = int'(ID_Instruction[5:0]);
    is_jr = JR_ON && (op == 0) && (fn == 8);
    br  = (op inside {1, 4, 5, 6, 7}) || is_jr;
    jmp = (op inside {2, 3}) || is_jr;
    if (!(op inside {2, 3}))           srcs.push_back(rs);
    if (op inside {0, 4, 5, 40, 41, 43}) srcs.push_back(rt);
    lu = 1'b0;
    bh = 1'b0;
    foreach (srcs[k]) begin
      if (srcs[k] != 0) begin
        if (EX_memRead != 0 && srcs[k] == int'(EX_Rd)) lu = 1'b1;
        if (br && EX_regWrite != 0 && srcs[k] == int'(EX_Rd)) bh = 1'b1;
        if (br && MEM_memRead && srcs[k] == int'(MEM_Rd)) bh = 1'b1;
      end
    end
    st = !Rst && (lu || bh);
    fl = !Rst && !st && ((br && comp_in) || jmp);
  endtask

  always @(posedge Clk) begin
    bit st, fl;
    model(st, fl);
    if (Rst) begin
      m_scnt = 0;
      m_fcnt = 0;
    end else begin
      if (st && m_scnt < 65535) m_scnt++;
      if (fl && m_fcnt < 65535) m_fcnt++;
    end
  end

  always @(negedge Clk) begin
    bit st, fl;
    if (chk_en) begin
      model(st, fl);
      check("m_stall_mux", 32'(stall_mux), 32'(st));
      check("m_pcoff", 32'(PCoff), 32'(st));
      check("m_ifid_off", 32'(IFID_writeOff), 32'(st));
      check("m_flush", 32'(flush), 32'(fl));
      check("m_stall_count", 32'(stall_count), 32'(m_scnt));
      check("m_flush_count", 32'(flush_count), 32'(m_fcnt));
    end
  end

  typedef struct {
    logic [31:0] ins;
    bit          comp;
    logic [4:0]  exrd;
    logic [1:0]  exrw;
    logic [1:0]  exmr;
    logic [4:0]  memrd;
    bit          memrw;
    bit          memmr;
    bit          es;
    bit          ef;
  } vec_t;

  vec_t vecs[$];

  task automatic drive(input vec_t v);
    ID_Instruction = v.ins;
    comp_in        = v.comp;
    EX_Rd          = v.exrd;
    EX_regWrite    = v.exrw;
    EX_memRead     = v.exmr;
    MEM_Rd         = v.memrd;
    MEM_regWrite   = v.memrw;
    MEM_memRead    = v.memmr;
  endtask

  initial begin
    vec_t idle, stall_v, jmp_v;
    idle    = '{32'h20040000, 1'b0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    stall_v = '{32'h20A40000, 1'b0, 5'd5, 2'd0, 2'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    jmp_v   = '{32'h08000000, 1'b0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};

    vecs.push_back(idle);                                                          // addi rs=0
    vecs.push_back('{32'h20040001, 1'b0, 5'd0, 2'd0, 2'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}); // r0 excluded
    vecs.push_back(stall_v);                                                       // load-use on rs
    vecs.push_back('{32'h10640000, 1'b1, 5'd4, 2'd1, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0}); // beq EX hazard
    vecs.push_back('{32'h10640000, 1'b1, 5'd4, 2'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1}); // beq taken
    vecs.push_back(jmp_v);                                                         // j
    vecs.push_back('{32'h10640000, 1'b0, 5'd0, 2'd0, 2'd0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0}); // beq MEM load
    vecs.push_back('{32'h10640000, 1'b0, 5'd0, 2'd0, 2'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0}); // MEM ALU ignored
    vecs.push_back('{32'hAC640000, 1'b0, 5'd4, 2'd0, 2'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0}); // sw reads rt
    vecs.push_back('{32'h8C640000, 1'b0, 5'd4, 2'd0, 2'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}); // lw ignores rt
    vecs.push_back('{32'h18600000, 1'b1, 5'd3, 2'd2, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0}); // blez EX hazard
    vecs.push_back('{32'h0CA00000, 1'b0, 5'd5, 2'd0, 2'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1}); // jal ignores rs
    vecs.push_back('{32'h03E00008, 1'b0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, JR_ON}); // jr plain
    vecs.push_back('{32'h03E00008, 1'b0, 5'd31, 2'd1, 2'd0, 5'd0, 1'b0, 1'b0, JR_ON, 1'b0}); // jr EX write
    vecs.push_back('{32'h00642020, 1'b0, 5'd4, 2'd0, 2'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0}); // add rt load-use
    vecs.push_back('{32'h14640000, 1'b1, 5'd7, 2'd1, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1}); // bne no match

    // Reset held with a jump in ID: everything quiet, counters cleared.
    Rst = 1'b1;
    drive(jmp_v);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("rst_stall", 32'(stall_mux), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_pcoff", 32'(PCoff), 32'd0);
    check("rst_ifid", 32'(IFID_writeOff), 32'd0);
    check("rst_scnt", 32'(stall_count), 32'd0);
    check("rst_fcnt", 32'(flush_count), 32'd0);
    chk_en = 1'b1;

    // Stall held across exactly three rising edges.
    @(posedge Clk); #1;
    Rst = 1'b0;
    drive(stall_v);
    repeat (3) @(posedge Clk);
    #1 drive(idle);
    @(negedge Clk);
    check("stall_cnt_3", 32'(stall_count), 32'd3);
    check("flush_cnt_0", 32'(flush_count), 32'd0);

    foreach (vecs[i]) begin
      @(posedge Clk); #1;
      drive(vecs[i]);
      @(negedge Clk);
      check($sformatf("vec%0d_stall", i), 32'(stall_mux), 32'(vecs[i].es));
      check($sformatf("vec%0d_pcoff", i), 32'(PCoff), 32'(vecs[i].es));
      check($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].ef));
    end

    // Reset in the middle of activity wins over counting.
    @(posedge Clk); #1;
    Rst = 1'b1;
    drive(jmp_v);
    @(negedge Clk);
    check("rst2_flush", 32'(flush), 32'd0);
    check("rst2_stall", 32'(stall_mux), 32'd0);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("rst2_scnt", 32'(stall_count), 32'd0);
    check("rst2_fcnt", 32'(flush_count), 32'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port ID_Instruction, input, 32 bits: the instruction in the ID stage.
REQ-004 SHALL have port comp_in, input, 1 bit: ID-stage branch comparator result, 1 = branch taken.
REQ-005 SHALL have port EX_Rd, input, 5 bits: destination register of the EX-stage instruction.
REQ-006 SHALL have port EX_regWrite, input, 2 bits: EX register-write control, asserted when nonzero.
REQ-007 SHALL have port EX_memRead, input, 2 bits: EX load control, asserted when nonzero.
REQ-008 SHALL have port MEM_Rd, input, 5 bits: destination register of the MEM-stage instruction.
REQ-009 SHALL have ports MEM_regWrite and MEM_memRead, inputs, 1 bit each: MEM-stage register-write and load controls.
REQ-010 SHALL have port stall_mux, output, 1 bit: 1 zeroes the ID/EX control signals (bubble).
REQ-011 SHALL have port flush, output, 1 bit: 1 flushes the IF/ID register.
REQ-012 SHALL have ports PCoff and IFID_writeOff, outputs, 1 bit each: 1 holds the PC and the IF/ID register.
REQ-013 SHALL have ports stall_count and flush_count, outputs, 16 bits each: saturating event counters.

Function
REQ-014 SHALL decode the instruction as opcode = [31:26], rs = [25:21], rt = [20:16], funct = [5:0].
REQ-015 SHALL treat rs as read by every instruction except j (000010) and jal (000011).
REQ-016 SHALL treat rt as read only by R-type (000000), beq (000100), bne (000101), sw (101011), sh (101001) and sb (101000).
REQ-017 SHALL treat beq, bne, blez (000110), bgtz (000111) and REGIMM (000001) as branches, and j and jal as jumps.
REQ-018 SHALL never count a match on register 0 as a hazard.
REQ-019 SHALL signal a load-use hazard when EX_memRead is nonzero and EX_Rd equals a register the ID instruction reads.
REQ-020 SHALL signal a branch hazard when the ID instruction is a branch and either (a) EX_regWrite is nonzero and EX_Rd equals a branch source, or (b) MEM_memRead is 1 and MEM_Rd equals a branch source.
REQ-021 SHALL set stall = load-use OR branch hazard; while stall is 1, stall_mux, PCoff and IFID_writeOff SHALL all be 1, otherwise all 0.
REQ-022 SHALL set flush = not stall AND ((branch AND comp_in) OR jump); a stall takes priority over a flush.
REQ-023 SHALL derive all hazard outputs combinationally from the current inputs, with zero latency.
REQ-024 SHALL increment stall_count by 1 on each rising edge where stall is 1, saturating at 16'hFFFF.
REQ-025 SHALL increment flush_count by 1 on each rising edge where flush is 1, saturating at 16'hFFFF.
REQ-026 SHALL treat the MEM_regWrite input as unused for hazard decisions; ALU results in MEM are resolved by forwarding.

Reset
REQ-027 SHALL, while Rst = 1, force stall_mux, flush, PCoff and IFID_writeOff to 0.
REQ-028 SHALL clear stall_count and flush_count to 0 on a rising edge with Rst = 1.
REQ-029 SHALL give reset priority over any counter increment in the same cycle.

Configuration
REQ-030 SHALL, with macro HAZARD_JR_EN defined, treat jr (opcode 000000, funct 001000) as a branch for REQ-020 and as a jump for REQ-022.
REQ-031 SHALL, without HAZARD_JR_EN, treat jr as an ordinary R-type instruction.

Structure
REQ-032 SHALL place the opcode and funct constants and the counter width in a shared package, hazard_pkg.
REQ-033 SHALL implement the instruction decoding (rs/rt usage, branch, jump) as one sub-module, hazard_decode.

Verification
REQ-034 SHALL check: all controls 0, instr 0x20040000 (addi, rs = 0) -> all four hazard outputs 0.
REQ-035 SHALL check: EX_memRead = 1, EX_Rd = 0, instr 0x20040001 -> no stall, because register 0 is excluded.
REQ-036 SHALL check: EX_memRead = 1, EX_Rd = 5, instr 0x20A40000 (rs = 5) -> stall_mux = PCoff = IFID_writeOff = 1, flush = 0.
REQ-037 SHALL check: beq rs = 3, rt = 4 (0x10640000), EX_regWrite = 1, EX_Rd = 4, comp_in = 1 -> stall = 1, flush = 0; then EX_regWrite = 0 -> flush = 1.
REQ-038 SHALL check: j (0x08000000) -> flush = 1; with Rst held, every output stays 0 and both counters read 0 on the next edge.
REQ-039 SHALL check: stall held for 3 edges after reset -> stall_count = 3.
